// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle: ID/EX/MEM hazard inputs plus stall/flush controls.
// master = pipeline side driving hazard info, slave = stall controller.
interface hazard_stall_ctrl_if;
  logic [4:0]  iID_NumRs;
  logic [4:0]  iID_NumRt;
  logic        iID_UsesRs;
  logic        iID_UsesRt;
  logic        iID_Branch;
  logic        iID_MulDiv;
  logic        iID_ReadsHiLo;
  logic [4:0]  iEX_NumRd;
  logic        iEX_RegWrite;
  logic        iEX_MemRead;
  logic [4:0]  iMEM_NumRd;
  logic        iMEM_MemRead;
  logic        iBranchTaken;
  logic        iJump;
  logic        iMemBusy;
  logic        oPCWrite;
  logic        oIFID_Write;
  logic        oIFID_Flush;
  logic        oIDEX_Flush;
  logic        oLock;
  logic [31:0] oStallCount;

  modport master (
    output iID_NumRs, iID_NumRt, iID_UsesRs, iID_UsesRt, iID_Branch, iID_MulDiv,
           iID_ReadsHiLo, iEX_NumRd, iEX_RegWrite, iEX_MemRead, iMEM_NumRd,
           iMEM_MemRead, iBranchTaken, iJump, iMemBusy,
    input  oPCWrite, oIFID_Write, oIFID_Flush, oIDEX_Flush, oLock, oStallCount
  );

  modport slave (
    input  iID_NumRs, iID_NumRt, iID_UsesRs, iID_UsesRt, iID_Branch, iID_MulDiv,
           iID_ReadsHiLo, iEX_NumRd, iEX_RegWrite, iEX_MemRead, iMEM_NumRd,
           iMEM_MemRead, iBranchTaken, iJump, iMemBusy,
    output oPCWrite, oIFID_Write, oIFID_Flush, oIDEX_Flush, oLock, oStallCount
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage MIPS core: load-use, branch operand, HI/LO busy, memory wait.
// Outputs are combinational off registered state; HAZ_PERF_CNT_EN adds the oLock cycle counter.
module hazard_stall_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic               iCLK,
  input  logic               iRST,
  hazard_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_STALL, S_MEMWAIT} state_t;

  state_t           r_state;
  state_t           r_saved;
  state_t           w_eff;
  logic [1:0]       r_rem;
  logic [CNT_W-1:0] r_mdc;

  logic w_rs_use, w_rt_use;
  logic w_ex_dep, w_mem_dep;
  logic w_need1, w_need2;
  logic w_fsm_stall, w_md_stall, w_stall, w_issue;

  // A branch compares both operands in ID, so it reads rs and rt regardless of the use flags.
  assign w_rs_use = bus.iID_UsesRs | bus.iID_Branch;
  assign w_rt_use = bus.iID_UsesRt | bus.iID_Branch;

  assign w_ex_dep  = (w_rs_use && bus.iID_NumRs != 5'd0 && bus.iID_NumRs == bus.iEX_NumRd) ||
                     (w_rt_use && bus.iID_NumRt != 5'd0 && bus.iID_NumRt == bus.iEX_NumRd);
  assign w_mem_dep = (w_rs_use && bus.iID_NumRs != 5'd0 && bus.iID_NumRs == bus.iMEM_NumRd) ||
                     (w_rt_use && bus.iID_NumRt != 5'd0 && bus.iID_NumRt == bus.iMEM_NumRd);

  assign w_need2 = bus.iEX_MemRead && w_ex_dep && bus.iID_Branch;
  assign w_need1 = (bus.iEX_MemRead && w_ex_dep) ||
                   (bus.iEX_RegWrite && !bus.iEX_MemRead && bus.iID_Branch && w_ex_dep) ||
                   (bus.iMEM_MemRead && bus.iID_Branch && w_mem_dep);

  // Once memory releases, act on the frozen state in the same cycle.
  assign w_eff       = (r_state == S_MEMWAIT) ? r_saved : r_state;
  assign w_fsm_stall = (w_eff == S_STALL) || (w_eff == S_IDLE && (w_need1 || w_need2));
  assign w_md_stall  = (r_mdc != '0) && (bus.iID_ReadsHiLo || bus.iID_MulDiv);
  assign w_stall     = w_fsm_stall || w_md_stall;
  assign w_issue     = bus.iID_MulDiv && !w_stall && !bus.iMemBusy;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= S_IDLE;
      r_saved <= S_IDLE;
      r_rem   <= 2'd0;
    end else if (bus.iMemBusy) begin
      r_state <= S_MEMWAIT;
      if (r_state != S_MEMWAIT) r_saved <= r_state;
    end else begin
      case (w_eff)
        S_IDLE: begin
          if (w_need2) begin
            r_state <= S_STALL;
            r_rem   <= 2'd1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_STALL: begin
          r_rem   <= r_rem - 2'd1;
          r_state <= (r_rem == 2'd1) ? S_IDLE : S_STALL;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)                r_mdc <= '0;
    else if (w_issue)        r_mdc <= CNT_W'(MD_LATENCY);
    else if (r_mdc != '0)    r_mdc <= r_mdc - 1'b1;
  end

  always_comb begin
    bus.oPCWrite    = 1'b1;
    bus.oIFID_Write = 1'b1;
    bus.oIFID_Flush = 1'b0;
    bus.oIDEX_Flush = 1'b0;
    bus.oLock       = 1'b0;
    if (bus.iMemBusy) begin
      bus.oPCWrite    = 1'b0;
      bus.oIFID_Write = 1'b0;
      bus.oLock       = 1'b1;
    end else if (w_stall) begin
      bus.oPCWrite    = 1'b0;
      bus.oIFID_Write = 1'b0;
      bus.oIDEX_Flush = 1'b1;
      bus.oLock       = 1'b1;
    end else begin
      bus.oIFID_Flush = bus.iBranchTaken | bus.iJump;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)           r_stall_cnt <= 32'h0;
    else if (bus.oLock) r_stall_cnt <= r_stall_cnt + 32'h1;
  end

  assign bus.oStallCount = r_stall_cnt;
`else
  assign bus.oStallCount = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: driver pushes hand-computed expectations, monitor checks at negedge.
module tb_hazard_stall_ctrl;

  typedef struct packed {
    logic [4:0] rs, rt;
    logic       urs, urt, br, md, hilo;
    logic [4:0] exrd;
    logic       exw, exld;
    logic [4:0] memrd;
    logic       memld, tk, jmp, busy, rst;
  } in_t;

  typedef struct packed {
    logic [4:0]  o;      // {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, Lock}
    logic        ck;
    logic [31:0] cnt;
    logic [15:0] id;
  } exp_t;

  localparam logic [4:0] E_FREE = 5'b11000;
  localparam logic [4:0] E_FLSH = 5'b11100;
  localparam logic [4:0] E_STL  = 5'b00011;
  localparam logic [4:0] E_MW   = 5'b00001;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  hazard_stall_ctrl_if bus();

  hazard_stall_ctrl #(.MD_LATENCY(32), .CNT_W(6)) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .bus (bus)
  );

  always #5 iCLK = ~iCLK;

  exp_t  sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    vec_id  = 0;
  logic [31:0] cnt_exp = 32'h0;
  in_t   IDLE_V = '0;

  task automatic apply(input in_t v);
    bus.iID_NumRs     = v.rs;
    bus.iID_NumRt     = v.rt;
    bus.iID_UsesRs    = v.urs;
    bus.iID_UsesRt    = v.urt;
    bus.iID_Branch    = v.br;
    bus.iID_MulDiv    = v.md;
    bus.iID_ReadsHiLo = v.hilo;
    bus.iEX_NumRd     = v.exrd;
    bus.iEX_RegWrite  = v.exw;
    bus.iEX_MemRead   = v.exld;
    bus.iMEM_NumRd    = v.memrd;
    bus.iMEM_MemRead  = v.memld;
    bus.iBranchTaken  = v.tk;
    bus.iJump         = v.jmp;
    bus.iMemBusy      = v.busy;
    iRST              = v.rst;
  endtask

  task automatic step(input in_t v, input logic [4:0] e, input logic ck);
    exp_t x;
    @(posedge iCLK);
    #1;
    apply(v);
    if (v.rst) cnt_exp = 32'h0;
    x.o  = e;
    x.ck = ck;
`ifdef HAZ_PERF_CNT_EN
    x.cnt = cnt_exp;
`else
    x.cnt = 32'h0;
`endif
    x.id = 16'(vec_id);
    vec_id++;
    sb.push_back(x);
    if (!v.rst && e[0]) cnt_exp = cnt_exp + 32'h1;
  endtask

  always @(negedge iCLK) begin
    exp_t e;
    logic [4:0] got;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {bus.oPCWrite, bus.oIFID_Write, bus.oIFID_Flush, bus.oIDEX_Flush, bus.oLock};
      n_tests++;
      if (got !== e.o) begin
        n_fail++;
        $display("FAIL vec%0d ctrl {pcw,ifidw,ifidf,idexf,lock} got=%b exp=%b", e.id, got, e.o);
      end
      if (e.ck) begin
        n_tests++;
        if (bus.oStallCount !== e.cnt) begin
          n_fail++;
          $display("FAIL vec%0d stall_count got=%0d exp=%0d", e.id, bus.oStallCount, e.cnt);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    in_t v;
    apply(IDLE_V);
    iRST = 1'b1;

    // reset state
    v = IDLE_V; v.rst = 1'b1;              step(v, E_FREE, 1'b1);
    v = IDLE_V;                            step(v, E_FREE, 1'b1);

    // load-use on rs, then on rt, then the non-hazard corner cases
    v = IDLE_V; v.rs = 5'd2; v.urs = 1; v.rt = 5'd5; v.urt = 1;
    v.exrd = 5'd2; v.exw = 1; v.exld = 1;  step(v, E_STL, 1'b0);
    v.exrd = 5'd0; v.exw = 0; v.exld = 0;  step(v, E_FREE, 1'b0);
    v = IDLE_V; v.rs = 5'd1; v.urs = 1; v.rt = 5'd2; v.urt = 1;
    v.exrd = 5'd2; v.exw = 1; v.exld = 1;  step(v, E_STL, 1'b0);
    v = IDLE_V; v.rs = 5'd0; v.urs = 1; v.exrd = 5'd0; v.exw = 1; v.exld = 1;
                                           step(v, E_FREE, 1'b0);
    v = IDLE_V; v.rs = 5'd2; v.urs = 0; v.exrd = 5'd2; v.exw = 1; v.exld = 1;
                                           step(v, E_FREE, 1'b1);

    // load followed by taken beq on the loaded register: two stalls, then flush
    v = IDLE_V; v.br = 1; v.rs = 5'd3; v.tk = 1; v.exrd = 5'd3; v.exw = 1; v.exld = 1;
                                           step(v, E_STL, 1'b0);
    v = IDLE_V; v.br = 1; v.rs = 5'd3; v.tk = 1; v.memrd = 5'd3; v.memld = 1;
                                           step(v, E_STL, 1'b0);
    v = IDLE_V; v.br = 1; v.rs = 5'd3; v.tk = 1;
                                           step(v, E_FLSH, 1'b0);
    v = IDLE_V;                            step(v, E_FREE, 1'b1);

    // ALU result feeding branch, MEM load feeding branch, plain jump
    v = IDLE_V; v.br = 1; v.rs = 5'd4; v.exrd = 5'd4; v.exw = 1;
                                           step(v, E_STL, 1'b0);
    v = IDLE_V; v.br = 1; v.rs = 5'd4; v.memrd = 5'd4;
                                           step(v, E_FREE, 1'b0);
    v = IDLE_V; v.br = 1; v.rt = 5'd6; v.memrd = 5'd6; v.memld = 1;
                                           step(v, E_STL, 1'b0);
    v = IDLE_V; v.br = 1; v.rt = 5'd6;     step(v, E_FREE, 1'b0);
    v = IDLE_V; v.jmp = 1;                 step(v, E_FLSH, 1'b1);

    // div issue, three unrelated slots, then mflo waits 29 cycles
    v = IDLE_V; v.md = 1;                  step(v, E_FREE, 1'b0);
    for (int i = 0; i < 3; i++) begin
      v = IDLE_V;                          step(v, E_FREE, 1'b0);
    end
    for (int i = 0; i < 29; i++) begin
      v = IDLE_V; v.hilo = 1;              step(v, E_STL, 1'b0);
    end
    v = IDLE_V; v.hilo = 1;                step(v, E_FREE, 1'b1);

    // memory wait in the middle of the load-branch stall; taken flush held off throughout
    v = IDLE_V; v.br = 1; v.rs = 5'd3; v.tk = 1; v.exrd = 5'd3; v.exw = 1; v.exld = 1;
                                           step(v, E_STL, 1'b0);
    for (int i = 0; i < 4; i++) begin
      v = IDLE_V; v.br = 1; v.rs = 5'd3; v.tk = 1; v.memrd = 5'd3; v.memld = 1; v.busy = 1;
                                           step(v, E_MW, 1'b0);
    end
    v = IDLE_V; v.br = 1; v.rs = 5'd3; v.tk = 1; v.memrd = 5'd3; v.memld = 1;
                                           step(v, E_STL, 1'b0);
    v = IDLE_V; v.br = 1; v.rs = 5'd3; v.tk = 1;
                                           step(v, E_FLSH, 1'b0);
    v = IDLE_V;                            step(v, E_FREE, 1'b1);

    // second div blocked by the first, then async reset with mdc at 10
    v = IDLE_V; v.md = 1;                  step(v, E_FREE, 1'b0);
    v = IDLE_V; v.md = 1;                  step(v, E_STL, 1'b0);
    for (int i = 0; i < 21; i++) begin
      v = IDLE_V;                          step(v, E_FREE, 1'b0);
    end
    v = IDLE_V; v.hilo = 1;                step(v, E_STL, 1'b1);
    v = IDLE_V; v.hilo = 1; v.rst = 1;     step(v, E_FREE, 1'b1);
    v = IDLE_V; v.hilo = 1;                step(v, E_FREE, 1'b0);
    v = IDLE_V;                            step(v, E_FREE, 1'b1);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge iCLK);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
